// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer:
// the datapath width, the number of RUN iterations and the FSM state encoding.
package mult_pkg;

  localparam int WIDTH     = 32;
  localparam int RUN_ITERS = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    RUN    = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/FullAdder.sv
// Single shared WIDTH-bit adder computing a + b + carry_in with carry out;
// every arithmetic step of the multiplier goes through this one instance.
module FullAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/mult_sequencer.sv
// Iterative 32x32 multiplier (MULT/MULTU) built around one shared adder.
// Define MULT_SIGNED_EN to honour signed_op and build the NEG_* sign-fixup states.
module mult_sequencer #(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mult_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_ITERS - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CNT_W-1:0]   r_count;

  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH-1:0]   w_add_b;
  logic               w_add_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

`ifdef MULT_SIGNED_EN
  logic               r_signed;
  logic               r_sign_diff;
  logic               r_carry;
`else
  logic               w_unused_signed_op;
  assign w_unused_signed_op = signed_op;
`endif

  FullAdder #(.WIDTH(WIDTH)) u_adder (
    .a         (w_add_a),
    .b         (w_add_b),
    .carry_in  (w_add_cin),
    .sum       (w_sum),
    .carry_out (w_cout)
  );

  // Adder operand steering: two's-complement negation in NEG_*, accumulate in RUN
  always_comb begin
    w_add_a   = r_hi;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case (r_state)
      RUN: begin
        w_add_a = r_hi;
        w_add_b = r_lo[0] ? r_mcand : '0;
      end
`ifdef MULT_SIGNED_EN
      NEG_A: begin
        w_add_a   = ~r_mcand;
        w_add_cin = 1'b1;
      end
      NEG_B, NEG_LO: begin
        w_add_a   = ~r_lo;
        w_add_cin = 1'b1;
      end
      NEG_HI: begin
        w_add_a   = ~r_hi;
        w_add_cin = r_carry;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef MULT_SIGNED_EN
          w_next = signed_op ? NEG_A : RUN;
`else
          w_next = RUN;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      NEG_A:  w_next = NEG_B;
      NEG_B:  w_next = RUN;
      NEG_LO: w_next = NEG_HI;
      NEG_HI: w_next = DONE;
`endif
      RUN: begin
        if (r_count == LAST_CNT) begin
`ifdef MULT_SIGNED_EN
          w_next = r_signed ? NEG_LO : DONE;
`else
          w_next = DONE;
`endif
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
`ifdef MULT_SIGNED_EN
      r_signed    <= 1'b0;
      r_sign_diff <= 1'b0;
      r_carry     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= operand_a;
            r_lo    <= operand_b;
            r_hi    <= '0;
            r_count <= '0;
`ifdef MULT_SIGNED_EN
            r_signed    <= signed_op;
            r_sign_diff <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          // Carry becomes the new MSB of hi; lo shifts out the consumed multiplier bit
          {r_hi, r_lo} <= {w_cout, w_sum, r_lo[WIDTH-1:1]};
          r_count      <= r_count + 1'b1;
        end
`ifdef MULT_SIGNED_EN
        NEG_A: if (r_mcand[WIDTH-1]) r_mcand <= w_sum;
        NEG_B: if (r_lo[WIDTH-1])    r_lo    <= w_sum;
        NEG_LO: begin
          if (r_sign_diff) begin
            r_lo    <= w_sum;
            r_carry <= w_cout;
          end
        end
        NEG_HI: if (r_sign_diff) r_hi <= w_sum;
`endif
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
